video_token_capture: RTL

- Synthesizable capture stage directly downstream of the top-level video output.
- Samples 18-bit RGB on each pixel-clock-enable rising edge and detects line and frame boundaries from the blanking and vertical-timing strobes.
- Emits an ordered token stream (pixel, end-of-line, end-of-frame) through a first-word-fall-through FIFO with a valid/ready handshake.
- Used by the hardware frame grabber and the bench video logger.

---
 rtl/video_token_capture.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/video_token_capture.sv
// Video capture stage: samples RGB on pixel strobes and turns line/frame timing edges
// into an ordered pixel / end-of-line / end-of-frame token stream through a FWFT FIFO.
module video_token_capture #(
    parameter int DEPTH       = 16,
    parameter int SKIP_FRAMES = 1
) (
    input  logic        clk_main,
    input  logic        nreset,
    input  logic        enable,
    input  logic [5:0]  video_r,
    input  logic [5:0]  video_g,
    input  logic [5:0]  video_b,
    input  logic        V6M,
    input  logic        NHBK,
    input  logic        HVOT,
    output logic        tok_valid,
    input  logic        tok_ready,
    output logic [1:0]  tok_type,
    output logic [17:0] tok_data,
    output logic        overflow,
    output logic [7:0]  drop_count,
    output logic [7:0]  frame_count,
    output logic        capturing
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] TOK_PIXEL = 2'b00;
    localparam logic [1:0] TOK_LINE  = 2'b01;
    localparam logic [1:0] TOK_FRAME = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  skip_cnt;

    logic        v6m_s1, v6m_s2;
    logic        nhbk_s1, nhbk_s2;
    logic        hvot_s1, hvot_s2;
    logic [17:0] rgb_s1;

    logic        pix_ev, line_ev, frame_ev;
    logic        push, push_ok, pop, full, empty;
    logic [1:0]  push_type;
    logic [17:0] push_data;
    logic [1:0]  drops;
    logic [8:0]  drop_sum;

    logic [19:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;

    // s1 samples the raw inputs, s2 holds the previous s1 so edges are s1 vs s2.
    always_ff @(posedge clk_main or negedge nreset) begin
        if (!nreset) begin
            v6m_s1  <= 1'b0;
            v6m_s2  <= 1'b0;
            nhbk_s1 <= 1'b1;
            nhbk_s2 <= 1'b1;
            hvot_s1 <= 1'b1;
            hvot_s2 <= 1'b1;
            rgb_s1  <= '0;
        end else begin
            v6m_s1  <= V6M;
            v6m_s2  <= v6m_s1;
            nhbk_s1 <= NHBK;
            nhbk_s2 <= nhbk_s1;
            hvot_s1 <= HVOT;
            hvot_s2 <= hvot_s1;
            rgb_s1  <= {video_r, video_g, video_b};
        end
    end

    assign pix_ev   = v6m_s1 & ~v6m_s2 & nhbk_s1;
    assign line_ev  = nhbk_s1 & ~nhbk_s2;
    assign frame_ev = ~hvot_s1 & hvot_s2;

    // Frame beats line beats pixel; every losing event in the same cycle is a drop.
    always_comb begin
        push      = 1'b0;
        push_type = TOK_PIXEL;
        push_data = '0;
        drops     = 2'd0;
        if (state == ST_CAPTURE) begin
            if (frame_ev) begin
                push      = 1'b1;
                push_type = TOK_FRAME;
                drops     = {1'b0, line_ev} + {1'b0, pix_ev};
            end else if (line_ev) begin
                push      = 1'b1;
                push_type = TOK_LINE;
                drops     = {1'b0, pix_ev};
            end else if (pix_ev) begin
                push      = 1'b1;
                push_type = TOK_PIXEL;
                push_data = rgb_s1;
            end
        end
    end

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign tok_valid = ~empty;
    assign pop       = tok_valid & tok_ready;
    assign push_ok   = push & (~full | pop);
    assign drop_sum  = {1'b0, drop_count} + {7'b0, drops};

    assign tok_type  = tok_valid ? mem[rd_ptr[AW-1:0]][19:18] : 2'b00;
    assign tok_data  = tok_valid ? mem[rd_ptr[AW-1:0]][17:0]  : 18'h0;
    assign capturing = (state == ST_CAPTURE);

    always_ff @(posedge clk_main) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= {push_type, push_data};
        end
    end

    always_ff @(posedge clk_main or negedge nreset) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Control FSM plus the status counters it owns.
    always_ff @(posedge clk_main or negedge nreset) begin
        if (!nreset) begin
            state       <= ST_IDLE;
            skip_cnt    <= 4'd0;
            overflow    <= 1'b0;
            drop_count  <= 8'd0;
            frame_count <= 8'd0;
        end else begin
            if (!enable) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state    <= ST_ARM;
                        skip_cnt <= 4'(SKIP_FRAMES);
                        overflow <= 1'b0;
                    end
                    ST_ARM: begin
                        if (skip_cnt == 4'd0) begin
                            state <= ST_CAPTURE;
                        end else if (frame_ev) begin
                            skip_cnt <= skip_cnt - 4'd1;
                            if (skip_cnt == 4'd1) state <= ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: state <= ST_CAPTURE;
                    default:    state <= ST_IDLE;
                endcase
            end
            if (push && !push_ok) overflow <= 1'b1;
            if (push_ok && push_type == TOK_FRAME) frame_count <= frame_count + 8'd1;
            drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

endmodule
